btn_pattern_player: RTL and testbench



---
 rtl/btn_pattern_player.sv | 170 +++++++++++++++++
 tb/tb_btn_pattern_player.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/btn_pattern_player.sv
// Replays a programmed sequence of (button mask, hold length) steps onto a 4-bit button bus.
// Optional BTN_PLAYER_LOOP_EN adds a loop input that restarts the sequence instead of finishing.
module btn_pattern_player #(
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned LEN_W    = 8,
  parameter int unsigned TICK_DIV = 1,
  localparam int unsigned AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             reset,
`ifdef BTN_PLAYER_LOOP_EN
  input  logic             loop,
`endif
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [3:0]       wr_mask,
  input  logic [LEN_W-1:0] wr_len,
  input  logic             start,
  input  logic             abort,
  output logic [3:0]       BTN,
  output logic             busy,
  output logic             done,
  output logic [AW-1:0]    step_idx
);

  localparam int unsigned CW = LEN_W + $clog2(TICK_DIV) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLAY = 2'd1,
    S_FIN  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [AW-1:0]     idx_q, idx_d;
  logic [3:0]        btn_q, btn_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [3:0]        mask_q [DEPTH];
  logic [LEN_W-1:0]  len_q  [DEPTH];

  logic              loop_c;
  logic [AW-1:0]     nxt_idx_c;
  logic              nxt_valid_c;

`ifdef BTN_PLAYER_LOOP_EN
  assign loop_c = loop;
`else
  assign loop_c = 1'b0;
`endif

  // Hold counter preload: len*TICK_DIV-1, so a step lasts exactly len*TICK_DIV cycles.
  function automatic logic [CW-1:0] hold_of(input logic [LEN_W-1:0] len);
    return CW'(len) * CW'(TICK_DIV) - CW'(1);
  endfunction

  // Step memory; only writable while idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mask_q[i] <= '0;
        len_q[i]  <= '0;
      end
    end else if (wr_en && (state_q == S_IDLE)) begin
      mask_q[wr_addr] <= wr_mask;
      len_q[wr_addr]  <= wr_len;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      btn_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      btn_q   <= btn_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign nxt_idx_c   = idx_q + AW'(1);
  assign nxt_valid_c = (idx_q != AW'(DEPTH - 1)) && (len_q[nxt_idx_c] != '0);

  // Next-state and next-output logic; abort overrides everything.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    btn_d   = btn_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        btn_d  = '0;
        busy_d = 1'b0;
        idx_d  = '0;
        if (start && !wr_en) begin
          if (len_q[0] == '0) begin
            state_d = S_FIN;
            done_d  = 1'b1;
          end else begin
            state_d = S_PLAY;
            btn_d   = mask_q[0];
            busy_d  = 1'b1;
            cnt_d   = hold_of(len_q[0]);
          end
        end
      end
      S_PLAY: begin
        if (cnt_q == '0) begin
          if (nxt_valid_c) begin
            idx_d = nxt_idx_c;
            btn_d = mask_q[nxt_idx_c];
            cnt_d = hold_of(len_q[nxt_idx_c]);
          end else if (loop_c && (len_q[0] != '0)) begin
            idx_d  = '0;
            btn_d  = mask_q[0];
            cnt_d  = hold_of(len_q[0]);
            done_d = 1'b1;
          end else begin
            state_d = S_FIN;
            idx_d   = '0;
            btn_d   = '0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
        idx_d   = '0;
        btn_d   = '0;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        idx_d   = '0;
        btn_d   = '0;
        busy_d  = 1'b0;
      end
    endcase

    if (abort) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      idx_d   = '0;
      btn_d   = '0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
    end
  end

  assign BTN      = btn_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign step_idx = idx_q;

endmodule

// File: tb/tb_btn_pattern_player.sv
// Directed bench for btn_pattern_player: one instance at TICK_DIV=1, one at TICK_DIV=4.
module tb_btn_pattern_player;

  localparam int unsigned AW = 3;
  localparam int unsigned LW = 8;

  logic          clk = 1'b0;
  logic          reset, wr_en, start, abort, loop;
  logic [AW-1:0] wr_addr;
  logic [3:0]    wr_mask;
  logic [LW-1:0] wr_len;
  logic [3:0]    btn, btn4;
  logic          busy, busy4, done, done4;
  logic [AW-1:0] idx, idx4;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  btn_pattern_player #(.DEPTH(8), .LEN_W(LW), .TICK_DIV(1)) u_dut (
    .clk(clk), .reset(reset),
`ifdef BTN_PLAYER_LOOP_EN
    .loop(loop),
`endif
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_mask(wr_mask), .wr_len(wr_len),
    .start(start), .abort(abort),
    .BTN(btn), .busy(busy), .done(done), .step_idx(idx)
  );

  btn_pattern_player #(.DEPTH(8), .LEN_W(LW), .TICK_DIV(4)) u_dut4 (
    .clk(clk), .reset(reset),
`ifdef BTN_PLAYER_LOOP_EN
    .loop(loop),
`endif
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_mask(wr_mask), .wr_len(wr_len),
    .start(start), .abort(abort),
    .BTN(btn4), .busy(busy4), .done(done4), .step_idx(idx4)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input int a, input int m, input int l);
    wr_en   = 1'b1;
    wr_addr = AW'(a);
    wr_mask = 4'(m);
    wr_len  = LW'(l);
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic go();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || done || busy4 || done4) && n < 600) begin
      tick();
      n++;
    end
    chk("idle_wait", 32'(busy | done | busy4 | done4), 0);
  endtask

  initial begin
    reset = 1'b1; wr_en = 1'b0; start = 1'b0; abort = 1'b0; loop = 1'b0;
    wr_addr = '0; wr_mask = '0; wr_len = '0;
    tick(); tick();
    reset = 1'b0;
    chk("rst_btn", 32'(btn), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_idx", 32'(idx), 0);

    // Empty memory: immediate done, no busy
    go();
    chk("empty_done", 32'(done), 1);
    chk("empty_busy", 32'(busy), 0);
    chk("empty_btn", 32'(btn), 0);
    tick();
    chk("empty_done_drop", 32'(done), 0);
    chk("empty_busy2", 32'(busy), 0);

    // Three-step sequence, TICK_DIV=1
    wr(0, 4'b0001, 10);
    wr(1, 4'b0000, 10);
    wr(2, 4'b0001, 15);
    wr(3, 4'b0000, 0);
    go();
    for (int c = 1; c <= 35; c++) begin
      chk("seq_btn", 32'(btn), (c <= 10) ? 1 : (c <= 20) ? 0 : 1);
      chk("seq_idx", 32'(idx), (c <= 10) ? 0 : (c <= 20) ? 1 : 2);
      chk("seq_busy", 32'(busy), 1);
      chk("seq_done", 32'(done), 0);
      tick();
    end
    chk("seq_end_done", 32'(done), 1);
    chk("seq_end_btn", 32'(btn), 0);
    chk("seq_end_busy", 32'(busy), 0);
    chk("seq_end_idx", 32'(idx), 0);
    tick();
    chk("seq_done_drop", 32'(done), 0);
    wait_idle();

    // Single step with TICK_DIV=4
    wr(0, 4'b1010, 3);
    wr(1, 4'b0000, 0);
    go();
    for (int c = 1; c <= 12; c++) begin
      chk("div_btn", 32'(btn4), 32'hA);
      chk("div_done", 32'(done4), 0);
      tick();
    end
    chk("div_end_done", 32'(done4), 1);
    chk("div_end_btn", 32'(btn4), 0);
    chk("div_end_busy", 32'(busy4), 0);
    wait_idle();

    // All eight entries, one cycle each, no wrap
    for (int i = 0; i < 8; i++) wr(i, i + 1, 1);
    go();
    for (int c = 0; c < 8; c++) begin
      chk("full_btn", 32'(btn), 32'((c + 1) % 16));
      chk("full_idx", 32'(idx), 32'(c));
      chk("full_busy", 32'(busy), 1);
      chk("full_done", 32'(done), 0);
      tick();
    end
    chk("full_end_done", 32'(done), 1);
    chk("full_end_btn", 32'(btn), 0);
    chk("full_end_idx", 32'(idx), 0);
    tick();
    chk("full_after_busy", 32'(busy), 0);
    chk("full_after_btn", 32'(btn), 0);
    wait_idle();

    // Abort mid-step; a write while busy must be ignored
    wr(0, 4'b0011, 10);
    wr(1, 4'b0000, 0);
    go();
    tick(); tick();
    wr(0, 4'b1111, 5);
    tick();
    chk("abort_pre_btn", 32'(btn), 32'h3);
    chk("abort_pre_busy", 32'(busy), 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_btn", 32'(btn), 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_idx", 32'(idx), 0);
    chk("abort_done", 32'(done), 0);
    chk("abort_busy4", 32'(busy4), 0);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("abort_no_done", 32'(done), 0);
    end
    go();
    for (int c = 1; c <= 10; c++) begin
      chk("rerun_btn", 32'(btn), 32'h3);
      tick();
    end
    chk("rerun_done", 32'(done), 1);
    wait_idle();

    // start together with wr_en: write wins, start ignored
    wr_en = 1'b1; wr_addr = '0; wr_mask = 4'b0110; wr_len = LW'(2);
    start = 1'b1;
    tick();
    wr_en = 1'b0; start = 1'b0;
    chk("wrstart_busy", 32'(busy), 0);
    chk("wrstart_done", 32'(done), 0);
    tick();
    go();
    chk("wrstart_btn", 32'(btn), 32'h6);
    tick();
    chk("wrstart_btn2", 32'(btn), 32'h6);
    tick();
    chk("wrstart_end", 32'(done), 1);
    wait_idle();

    // Reset mid-playback clears outputs and memory
    go();
    chk("rstmid_pre", 32'(btn), 32'h6);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rstmid_btn", 32'(btn), 0);
    chk("rstmid_busy", 32'(busy), 0);
    chk("rstmid_done", 32'(done), 0);
    go();
    chk("rstmid_empty_done", 32'(done), 1);
    chk("rstmid_empty_busy", 32'(busy), 0);
    tick();

`ifdef BTN_PLAYER_LOOP_EN
    // Looping: continuous mask, done every pass, final pass after loop drops
    wr(0, 4'b0100, 2);
    loop = 1'b1;
    go();
    for (int c = 1; c <= 8; c++) begin
      chk("loop_btn", 32'(btn), 32'h4);
      chk("loop_busy", 32'(busy), 1);
      chk("loop_done", 32'(done), (c >= 3 && (c % 2) == 1) ? 1 : 0);
      if (c < 8) tick();
    end
    loop = 1'b0;
    tick();
    chk("loop_fin_done", 32'(done), 1);
    chk("loop_fin_btn", 32'(btn), 0);
    chk("loop_fin_busy", 32'(busy), 0);
    tick();
    chk("loop_fin_drop", 32'(done), 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
